dm_bus_access: RTL and testbench
================================

Name: dm_bus_access

Overview:
- MEM-stage load/store sequencer between the pipeline and a variable-latency data-memory bus (req/ack handshake).
- Stalls the pipeline while an access is outstanding.
- Stores: generates byte enables and lane-replicated write data.
- Loads: captures the raw 32-bit word and forwards it with read type and address low bits to the downstream read-data extender (sign/zero extension and lane select happen downstream).

Parameters:
- DM_ADDR_LIMIT, 32'h0000_3000: first byte address outside data memory; used only by the alignment/range check.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- mem_en  in  1  MEM-stage instruction is a load or store
- mem_we  in  1  1 = store, 0 = load
- addr  in  32  byte address
- wdata  in  32  store data (value in low bits)
- store_type  in  2  `StoreWord / `StoreHalf / `StoreByte
- read_type  in  3  `WordRead / `ByteSigned / `ByteUnsigned / `HalfSigned / `HalfUnsigned
- stall  out  1  freeze PC through EX/MEM
- rd_word  out  32  raw captured load word
- rd_type  out  3  registered read_type for the extender
- rd_addr_low  out  2  registered addr[1:0] for the extender
- rd_valid  out  1  one-cycle pulse: rd_* valid
- bus_req  out  1  bus request
- bus_we  out  1  bus write
- bus_addr  out  32  {addr[31:2], 2'b00}
- bus_wdata  out  32  lane-replicated store data
- bus_be  out  4  byte enables (0000 on loads)
- bus_ack  in  1  bus completion; bus_rdata valid the same cycle
- bus_rdata  in  32  read word
- exc_adel  out  1  load address error (feature only; tied 0 otherwise)
- exc_ades  out  1  store address error (feature only; tied 0 otherwise)

Behaviour:
- Reset values: state IDLE; bus_req, bus_we, rd_valid = 0; rd_word, bus_addr, bus_wdata = 0; bus_be = 0; rd_type = 0; rd_addr_low = 0.
- FSM: IDLE -> WAIT -> DONE -> IDLE.
- IDLE: when mem_en is high and there is no exception, register bus_addr, bus_we, bus_be, bus_wdata, rd_type and rd_addr_low; set bus_req = 1; go to WAIT.
- WAIT: hold bus_req and all bus_* outputs stable until bus_ack.
  - On bus_ack: drop bus_req; if a load, rd_word <= bus_rdata; go to DONE.
  - Stores leave rd_word unchanged.
- DONE: rd_valid = 1 for exactly one cycle, stall = 0, pipeline advances; return to IDLE.
  - DONE never launches a new request, even though mem_en is still asserted for the same instruction.
- stall (combinational) = (IDLE & mem_en & ~exc) | WAIT.
- Latency: ack in the first WAIT cycle gives 2 stall cycles and data in the 3rd cycle. Each extra ack wait adds 1 stall cycle.
- bus_ack is ignored in IDLE and DONE.
- Byte enables:
  - word -> 1111
  - half -> 0011 if addr[1] = 0, 1100 if addr[1] = 1
  - byte -> 0001 << addr[1:0]
- Write data:
  - byte -> {4{wdata[7:0]}}
  - half -> {2{wdata[15:0]}}
  - word -> wdata
- Reset mid-access (WAIT or DONE): next edge returns to IDLE, bus_req = 0, rd_valid = 0; a late ack is discarded.
- Reserved store_type or read_type codes behave as word.

Optional Feature:
- Macro: DM_ALIGN_CHECK_EN.
- With it, an exception is raised when any of these hold:
  - word access with addr[1:0] != 0
  - half access with addr[0] != 0
  - addr >= DM_ADDR_LIMIT
- On exception in IDLE with mem_en high: exc_adel (load) or exc_ades (store) is asserted combinationally for that cycle; no bus request, no stall, no rd_valid.
- Without the macro: both exception outputs are tied 0, the range is never checked, and misaligned low bits are silently truncated (word aligned down; half uses addr[1] only).

Decomposition:
- Shared Constants.v holds:
  - store-type codes (`StoreWord = 0, `StoreHalf = 1, `StoreByte = 2)
  - FSM state codes
  - the existing read-type codes
- One natural sub-module, dm_wd_ext: combinational byte-enable and write-data lane generator (store_type, addr[1:0], wdata -> be, wdata_rep).

Test Plan:
- Load word at addr 0x100, ack after 1 cycle, bus_rdata = 0xDEADBEEF -> stall high for 2 cycles, bus_addr = 0x100, bus_be = 0000, rd_word = 0xDEADBEEF, rd_type = `WordRead, rd_valid pulses once.
- Store byte at addr 0x203, wdata = 0x12345678 -> bus_be = 1000, bus_wdata = 0x78787878, bus_addr = 0x200.
- Store half at addr 0x42, wdata = 0xABCD -> bus_be = 1100, bus_wdata = 0xABCDABCD.
- Load with ack delayed 5 cycles -> stall high for 6 cycles, bus_* stable throughout, rd_valid exactly once.
- Reset asserted in WAIT, then ack arrives next cycle -> bus_req = 0 after the edge, no rd_valid, state IDLE, rd_word unchanged at 0.
- With DM_ALIGN_CHECK_EN: load word at 0x102 -> exc_adel = 1, stall = 0, bus_req stays 0. Store at 0x3000 -> exc_ades = 1.

Source files
------------

// File: rtl/dm_bus_access_pkg.sv
// Shared constants for the MEM-stage data-memory bus sequencer.
// Store/read type codes and FSM state encoding.
package dm_bus_access_pkg;

  localparam logic [1:0] STORE_WORD = 2'd0;
  localparam logic [1:0] STORE_HALF = 2'd1;
  localparam logic [1:0] STORE_BYTE = 2'd2;

  localparam logic [2:0] WORD_READ     = 3'd0;
  localparam logic [2:0] BYTE_SIGNED   = 3'd1;
  localparam logic [2:0] BYTE_UNSIGNED = 3'd2;
  localparam logic [2:0] HALF_SIGNED   = 3'd3;
  localparam logic [2:0] HALF_UNSIGNED = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } dm_state_e;

endpackage

// File: rtl/dm_wd_ext.sv
// Store lane generator: byte enables and replicated write data.
// Reserved store types fall through to a full-word store.
module dm_wd_ext
  import dm_bus_access_pkg::*;
(
  input  logic [1:0]  store_type,
  input  logic [1:0]  addr_low,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep
);

  // Lane select and replication by access size
  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    unique case (1'b1)
      (store_type == STORE_HALF): begin
        be        = addr_low[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      (store_type == STORE_BYTE): begin
        be        = 4'b0001 << addr_low;
        wdata_rep = {4{wdata[7:0]}};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata;
      end
    endcase
  end

endmodule

// File: rtl/dm_bus_access.sv
// MEM-stage load/store sequencer on a req/ack data bus.
// Optional alignment/range check: define DM_ALIGN_CHECK_EN.
module dm_bus_access
  import dm_bus_access_pkg::*;
`ifdef DM_ALIGN_CHECK_EN
#(
  parameter logic [31:0] DM_ADDR_LIMIT = 32'h0000_3000
)
`endif
(
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  store_type,
  input  logic [2:0]  read_type,
  output logic        stall,
  output logic [31:0] rd_word,
  output logic [2:0]  rd_type,
  output logic [1:0]  rd_addr_low,
  output logic        rd_valid,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        exc_adel,
  output logic        exc_ades
);

  dm_state_e   state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] rd_word_q, rd_word_d;
  logic [2:0]  rd_type_q, rd_type_d;
  logic [1:0]  rd_addr_low_q, rd_addr_low_d;

  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic        exc;

  dm_wd_ext u_wd_ext (
    .store_type (store_type),
    .addr_low   (addr[1:0]),
    .wdata      (wdata),
    .be         (be),
    .wdata_rep  (wdata_rep)
  );

`ifdef DM_ALIGN_CHECK_EN
  logic is_half;
  logic is_byte;
  logic misalign;

  // Access size, misalignment and range fault for the MEM-stage op
  always_comb begin
    if (mem_we) begin
      is_half = (store_type == STORE_HALF);
      is_byte = (store_type == STORE_BYTE);
    end else begin
      is_half = (read_type == HALF_SIGNED) ||
                (read_type == HALF_UNSIGNED);
      is_byte = (read_type == BYTE_SIGNED) ||
                (read_type == BYTE_UNSIGNED);
    end
    misalign = (is_half && addr[0]) ||
               (!is_half && !is_byte && (addr[1:0] != 2'b00));
    exc      = misalign || (addr >= DM_ADDR_LIMIT);
  end

  assign exc_adel = (state_q == ST_IDLE) && mem_en && exc && !mem_we;
  assign exc_ades = (state_q == ST_IDLE) && mem_en && exc && mem_we;
`else
  assign exc      = 1'b0;
  assign exc_adel = 1'b0;
  assign exc_ades = 1'b0;
`endif

  // Next-state, bus launch and load capture
  always_comb begin
    state_d       = state_q;
    bus_req_d     = bus_req_q;
    bus_we_d      = bus_we_q;
    bus_addr_d    = bus_addr_q;
    bus_wdata_d   = bus_wdata_q;
    bus_be_d      = bus_be_q;
    rd_word_d     = rd_word_q;
    rd_type_d     = rd_type_q;
    rd_addr_low_d = rd_addr_low_q;
    stall         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_en && !exc) begin
          stall         = 1'b1;
          state_d       = ST_WAIT;
          bus_req_d     = 1'b1;
          bus_we_d      = mem_we;
          bus_addr_d    = {addr[31:2], 2'b00};
          bus_be_d      = mem_we ? be : 4'b0000;
          bus_wdata_d   = mem_we ? wdata_rep : 32'h0;
          rd_type_d     = read_type;
          rd_addr_low_d = addr[1:0];
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (bus_ack) begin
          bus_req_d = 1'b0;
          state_d   = ST_DONE;
          if (!bus_we_q) begin
            rd_word_d = bus_rdata;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and bus/result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= 32'h0;
      bus_wdata_q   <= 32'h0;
      bus_be_q      <= 4'b0000;
      rd_word_q     <= 32'h0;
      rd_type_q     <= 3'd0;
      rd_addr_low_q <= 2'd0;
    end else begin
      state_q       <= state_d;
      bus_req_q     <= bus_req_d;
      bus_we_q      <= bus_we_d;
      bus_addr_q    <= bus_addr_d;
      bus_wdata_q   <= bus_wdata_d;
      bus_be_q      <= bus_be_d;
      rd_word_q     <= rd_word_d;
      rd_type_q     <= rd_type_d;
      rd_addr_low_q <= rd_addr_low_d;
    end
  end

  assign rd_valid    = (state_q == ST_DONE);
  assign rd_word     = rd_word_q;
  assign rd_type     = rd_type_q;
  assign rd_addr_low = rd_addr_low_q;
  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign bus_be      = bus_be_q;

endmodule

// File: tb/tb_dm_bus_access.sv
// Directed bench for dm_bus_access.
// Covers both builds of DM_ALIGN_CHECK_EN.
module tb_dm_bus_access;
  import dm_bus_access_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  store_type;
  logic [2:0]  read_type;
  logic        stall;
  logic [31:0] rd_word;
  logic [2:0]  rd_type;
  logic [1:0]  rd_addr_low;
  logic        rd_valid;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        exc_adel;
  logic        exc_ades;

  int tests = 0;
  int fails = 0;

  int          n_stall;
  int          n_valid;
  int          n_unstable;
  logic        done;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_be;
  logic        s_we;
  logic [31:0] c_word;
  logic [2:0]  c_type;
  logic [1:0]  c_low;

  dm_bus_access dut (
    .clk         (clk),
    .reset       (reset),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .addr        (addr),
    .wdata       (wdata),
    .store_type  (store_type),
    .read_type   (read_type),
    .stall       (stall),
    .rd_word     (rd_word),
    .rd_type     (rd_type),
    .rd_addr_low (rd_addr_low),
    .rd_valid    (rd_valid),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_be      (bus_be),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata),
    .exc_adel    (exc_adel),
    .exc_ades    (exc_ades)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One access; ack in WAIT cycle number dly (0 = first).
  task automatic access(input logic        we,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input logic [1:0]  st,
                        input logic [2:0]  rt,
                        input int          dly,
                        input logic [31:0] rdata);
    int waitc;
    @(negedge clk);
    mem_en     = 1'b1;
    mem_we     = we;
    addr       = a;
    wdata      = wd;
    store_type = st;
    read_type  = rt;
    bus_ack    = 1'b0;
    bus_rdata  = rdata;
    n_stall    = 0;
    n_valid    = 0;
    n_unstable = 0;
    done       = 1'b0;
    waitc      = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (stall) n_stall++;
      if (rd_valid) begin
        n_valid++;
        done   = 1'b1;
        c_word = rd_word;
        c_type = rd_type;
        c_low  = rd_addr_low;
      end
      if (bus_req) begin
        if (waitc == 0) begin
          s_addr  = bus_addr;
          s_wdata = bus_wdata;
          s_be    = bus_be;
          s_we    = bus_we;
        end else if (bus_addr !== s_addr ||
                     bus_wdata !== s_wdata ||
                     bus_be !== s_be ||
                     bus_we !== s_we) begin
          n_unstable++;
        end
        bus_ack = (waitc == dly);
        waitc++;
      end else begin
        bus_ack = 1'b0;
      end
      @(negedge clk);
    end
    mem_en  = 1'b0;
    bus_ack = 1'b0;
    #1;
    if (rd_valid) n_valid++;
  endtask

  initial begin
    reset      = 1'b1;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    addr       = 32'h0;
    wdata      = 32'h0;
    store_type = STORE_WORD;
    read_type  = WORD_READ;
    bus_ack    = 1'b0;
    bus_rdata  = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_word", rd_word, 32'h0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_be", 32'(bus_be), 32'h0);
    chk("rst_type", 32'(rd_type), 32'h0);

    // Ack while idle is ignored
    @(negedge clk);
    reset   = 1'b0;
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    chk("idle_ack_req", 32'(bus_req), 32'd0);
    chk("idle_ack_valid", 32'(rd_valid), 32'd0);

    // Load word 0x100, ack in first WAIT cycle
    access(1'b0, 32'h100, 32'h0, STORE_WORD, WORD_READ,
           0, 32'hDEAD_BEEF);
    chk("lw_done", 32'(done), 32'd1);
    chk("lw_stall", n_stall, 32'd2);
    chk("lw_valid", n_valid, 32'd1);
    chk("lw_addr", s_addr, 32'h100);
    chk("lw_be", 32'(s_be), 32'h0);
    chk("lw_we", 32'(s_we), 32'd0);
    chk("lw_word", c_word, 32'hDEAD_BEEF);
    chk("lw_type", 32'(c_type), 32'(WORD_READ));

    // Store byte at 0x203
    access(1'b1, 32'h203, 32'h1234_5678, STORE_BYTE, WORD_READ,
           1, 32'h5555_5555);
    chk("sb_stall", n_stall, 32'd3);
    chk("sb_valid", n_valid, 32'd1);
    chk("sb_be", 32'(s_be), 32'b1000);
    chk("sb_wdata", s_wdata, 32'h7878_7878);
    chk("sb_addr", s_addr, 32'h200);
    chk("sb_we", 32'(s_we), 32'd1);
    chk("sb_keep_word", c_word, 32'hDEAD_BEEF);

    // Store half at 0x42
    access(1'b1, 32'h42, 32'h0000_ABCD, STORE_HALF, WORD_READ,
           0, 32'h0);
    chk("sh_be", 32'(s_be), 32'b1100);
    chk("sh_wdata", s_wdata, 32'hABCD_ABCD);
    chk("sh_addr", s_addr, 32'h40);

    // Store half at 0x40, low lanes
    access(1'b1, 32'h40, 32'h0000_1357, STORE_HALF, WORD_READ,
           0, 32'h0);
    chk("sh0_be", 32'(s_be), 32'b0011);

    // Store byte at 0x21
    access(1'b1, 32'h21, 32'h0000_00A5, STORE_BYTE, WORD_READ,
           0, 32'h0);
    chk("sb1_be", 32'(s_be), 32'b0010);
    chk("sb1_wdata", s_wdata, 32'hA5A5_A5A5);

    // Reserved store type behaves as word
    access(1'b1, 32'h10, 32'hCAFE_F00D, 2'd3, WORD_READ,
           0, 32'h0);
    chk("srsv_be", 32'(s_be), 32'b1111);
    chk("srsv_wdata", s_wdata, 32'hCAFE_F00D);

    // Half load at 0x1006, ack in fifth WAIT cycle
    access(1'b0, 32'h1006, 32'h0, STORE_WORD, HALF_UNSIGNED,
           4, 32'h1122_3344);
    chk("lh_done", 32'(done), 32'd1);
    chk("lh_stall", n_stall, 32'd6);
    chk("lh_stable", n_unstable, 32'd0);
    chk("lh_valid", n_valid, 32'd1);
    chk("lh_addr", s_addr, 32'h1004);
    chk("lh_word", c_word, 32'h1122_3344);
    chk("lh_type", 32'(c_type), 32'(HALF_UNSIGNED));
    chk("lh_low", 32'(c_low), 32'd2);

`ifdef DM_ALIGN_CHECK_EN
    // Misaligned word load faults
    @(negedge clk);
    mem_en    = 1'b1;
    mem_we    = 1'b0;
    addr      = 32'h102;
    read_type = WORD_READ;
    #1;
    chk("adel", 32'(exc_adel), 32'd1);
    chk("adel_ades", 32'(exc_ades), 32'd0);
    chk("adel_stall", 32'(stall), 32'd0);
    @(negedge clk);
    #1;
    chk("adel_req", 32'(bus_req), 32'd0);
    chk("adel_valid", 32'(rd_valid), 32'd0);
    // Store beyond data memory faults
    mem_we     = 1'b1;
    addr       = 32'h3000;
    store_type = STORE_WORD;
    #1;
    chk("ades", 32'(exc_ades), 32'd1);
    chk("ades_stall", 32'(stall), 32'd0);
    @(negedge clk);
    mem_en = 1'b0;
    #1;
    chk("ades_req", 32'(bus_req), 32'd0);
`else
    // Misaligned word load truncates, no fault
    access(1'b0, 32'h102, 32'h0, STORE_WORD, WORD_READ,
           0, 32'h0BAD_F00D);
    chk("mis_addr", s_addr, 32'h100);
    chk("mis_stall", n_stall, 32'd2);
    chk("mis_low", 32'(c_low), 32'd2);
    chk("mis_exc", 32'(exc_adel), 32'd0);
    // Out-of-range store goes to the bus
    access(1'b1, 32'h3000, 32'h1, STORE_WORD, WORD_READ,
           0, 32'h0);
    chk("rng_addr", s_addr, 32'h3000);
    chk("rng_valid", n_valid, 32'd1);
`endif

    // Reset during WAIT, late ack discarded
    @(negedge clk);
    mem_en    = 1'b1;
    mem_we    = 1'b0;
    addr      = 32'h300;
    read_type = WORD_READ;
    @(negedge clk);
    #1;
    chk("rw_req", 32'(bus_req), 32'd1);
    reset  = 1'b1;
    mem_en = 1'b0;
    @(negedge clk);
    reset     = 1'b0;
    bus_ack   = 1'b1;
    bus_rdata = 32'hFFFF_FFFF;
    #1;
    chk("rw_req0", 32'(bus_req), 32'd0);
    chk("rw_valid", 32'(rd_valid), 32'd0);
    chk("rw_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("rw_word", rd_word, 32'h0);
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    chk("rw_valid2", 32'(rd_valid), 32'd0);
    chk("rw_word2", rd_word, 32'h0);
    chk("rw_req2", 32'(bus_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
